simmem_release_arbiter: RTL and testbench

// - Per-channel scheduler between releaser and message banks in the simulated memory controller.
// - Chooses which released ID the read-data and write-response banks emit next.
// - Eligible ID: releaser has enabled it and the bank holds a message for it.
// - Round-robin across eligible IDs; read bursts are locked until the last beat.
// - Drives the output valid, the granted ID and the bank pop strobe.

---
 rtl/simmem_release_arbiter_if.sv | 57 +++++
 rtl/simmem_release_arbiter.sv | 176 +++++++++++++++++
 tb/tb_simmem_release_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simmem_release_arbiter_if.sv
// Bundle between the release arbiter and its neighbours: the releaser enables,
// the bank occupancy flags, and the downstream read-data / write-response
// handshakes. The grant counters exist only when SIMMEM_ARB_STATS_EN is defined.
interface simmem_release_arbiter_if #(
  parameter int IDWidth  = 4,
  parameter int CntWidth = 32
);
  localparam int NumIds = 2 ** IDWidth;

  // Read-data channel
  logic [NumIds-1:0]  rd_release_en_i;
  logic [NumIds-1:0]  rd_avail_i;
  logic               rd_last_i;
  logic               rd_out_ready_i;
  logic               rd_out_valid_o;
  logic [IDWidth-1:0] rd_grant_id_o;
  logic               rd_pop_o;

  // Write-response channel
  logic [NumIds-1:0]  wr_release_en_i;
  logic [NumIds-1:0]  wr_avail_i;
  logic               wr_out_ready_i;
  logic               wr_out_valid_o;
  logic [IDWidth-1:0] wr_grant_id_o;
  logic               wr_pop_o;

`ifdef SIMMEM_ARB_STATS_EN
  logic [CntWidth-1:0] rd_grant_cnt_o;
  logic [CntWidth-1:0] wr_grant_cnt_o;
`endif

  if (CntWidth < 1) begin : g_bad_cnt_width
    $error("CntWidth must be at least 1");
  end

  // Arbiter side
  modport slave (
`ifdef SIMMEM_ARB_STATS_EN
    output rd_grant_cnt_o, wr_grant_cnt_o,
`endif
    input  rd_release_en_i, rd_avail_i, rd_last_i, rd_out_ready_i,
    output rd_out_valid_o, rd_grant_id_o, rd_pop_o,
    input  wr_release_en_i, wr_avail_i, wr_out_ready_i,
    output wr_out_valid_o, wr_grant_id_o, wr_pop_o
  );

  // Releaser / bank / downstream side
  modport master (
`ifdef SIMMEM_ARB_STATS_EN
    input  rd_grant_cnt_o, wr_grant_cnt_o,
`endif
    output rd_release_en_i, rd_avail_i, rd_last_i, rd_out_ready_i,
    input  rd_out_valid_o, rd_grant_id_o, rd_pop_o,
    output wr_release_en_i, wr_avail_i, wr_out_ready_i,
    input  wr_out_valid_o, wr_grant_id_o, wr_pop_o
  );
endinterface

// File: rtl/simmem_release_arbiter.sv
// Per-channel round-robin scheduler between the releaser and the message banks.
// An ID is eligible when the releaser has enabled it and its bank holds data.
// Read bursts keep the grant until the last beat; write responses are single.
// Every grant is followed by one idle bubble cycle.
// Optional grant counters: define SIMMEM_ARB_STATS_EN.
module simmem_release_arbiter #(
  parameter int IDWidth  = 4,
  parameter int CntWidth = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  simmem_release_arbiter_if.slave bus
);
  localparam int NumIds = 2 ** IDWidth;
  localparam logic [IDWidth-1:0] IdOne  = IDWidth'(1);
  localparam logic [IDWidth-1:0] IdZero = IDWidth'(0);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_GRANT = 2'd1,
    RD_LOCK  = 2'd2
  } rd_state_e;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_GRANT = 1'b1
  } wr_state_e;

  // Returns {found, id}: first set bit of elig at or after ptr, wrapping.
  function automatic logic [IDWidth:0] rr_pick(input logic [NumIds-1:0] elig,
                                               input logic [IDWidth-1:0] ptr);
    logic [IDWidth-1:0] idx;
    rr_pick = {1'b0, IdZero};
    // Walk from the farthest offset down so the nearest eligible ID wins.
    for (int i = NumIds - 1; i >= 0; i--) begin
      idx = ptr + IDWidth'(i);
      if (elig[idx]) begin
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  rd_state_e          rd_state_r;
  logic [IDWidth-1:0] rd_gid_r;
  logic [IDWidth-1:0] rd_ptr_r;
  logic               rd_valid_s;
  logic               rd_hs_s;
  logic [IDWidth:0]   rd_pick_s;

  wr_state_e          wr_state_r;
  logic [IDWidth-1:0] wr_gid_r;
  logic [IDWidth-1:0] wr_ptr_r;
  logic               wr_valid_s;
  logic               wr_hs_s;
  logic [IDWidth:0]   wr_pick_s;

  if (CntWidth < 1) begin : g_bad_cnt_width
    $error("CntWidth must be at least 1");
  end

  // Read valid: always up once granted; inside a burst it follows the bank.
  always_comb begin
    rd_valid_s = 1'b0;
    case (rd_state_r)
      RD_GRANT: rd_valid_s = 1'b1;
      RD_LOCK:  rd_valid_s = bus.rd_avail_i[rd_gid_r];
      default:  rd_valid_s = 1'b0;
    endcase
    rd_hs_s   = rd_valid_s & bus.rd_out_ready_i;
    rd_pick_s = rr_pick(bus.rd_release_en_i & bus.rd_avail_i, rd_ptr_r);
  end

  // Write valid: up for the whole grant, no lock phase.
  always_comb begin
    wr_valid_s = 1'b0;
    case (wr_state_r)
      WR_GRANT: wr_valid_s = 1'b1;
      default:  wr_valid_s = 1'b0;
    endcase
    wr_hs_s   = wr_valid_s & bus.wr_out_ready_i;
    wr_pick_s = rr_pick(bus.wr_release_en_i & bus.wr_avail_i, wr_ptr_r);
  end

  // Read FSM: arbitrate in idle, hold the ID until the burst's last beat leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_r <= RD_IDLE;
      rd_gid_r   <= IdZero;
      rd_ptr_r   <= IdZero;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (rd_pick_s[IDWidth]) begin
            rd_gid_r   <= rd_pick_s[IDWidth-1:0];
            rd_state_r <= RD_GRANT;
          end else begin
            rd_state_r <= RD_IDLE;
          end
        end
        RD_GRANT, RD_LOCK: begin
          if (rd_hs_s && bus.rd_last_i) begin
            rd_ptr_r   <= rd_gid_r + IdOne;
            rd_state_r <= RD_IDLE;
          end else if (rd_hs_s) begin
            rd_state_r <= RD_LOCK;
          end else begin
            rd_state_r <= rd_state_r;
          end
        end
        default: rd_state_r <= RD_IDLE;
      endcase
    end
  end

  // Write FSM: arbitrate in idle, any handshake ends the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_r <= WR_IDLE;
      wr_gid_r   <= IdZero;
      wr_ptr_r   <= IdZero;
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (wr_pick_s[IDWidth]) begin
            wr_gid_r   <= wr_pick_s[IDWidth-1:0];
            wr_state_r <= WR_GRANT;
          end else begin
            wr_state_r <= WR_IDLE;
          end
        end
        WR_GRANT: begin
          if (wr_hs_s) begin
            wr_ptr_r   <= wr_gid_r + IdOne;
            wr_state_r <= WR_IDLE;
          end else begin
            wr_state_r <= WR_GRANT;
          end
        end
        default: wr_state_r <= WR_IDLE;
      endcase
    end
  end

  assign bus.rd_out_valid_o = rd_valid_s;
  assign bus.rd_grant_id_o  = rd_gid_r;
  assign bus.rd_pop_o       = rd_hs_s;
  assign bus.wr_out_valid_o = wr_valid_s;
  assign bus.wr_grant_id_o  = wr_gid_r;
  assign bus.wr_pop_o       = wr_hs_s;

`ifdef SIMMEM_ARB_STATS_EN
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] rd_cnt_r;
  logic [CntWidth-1:0] wr_cnt_r;

  // Saturating counts of completed read bursts and write responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_r <= {CntWidth{1'b0}};
      wr_cnt_r <= {CntWidth{1'b0}};
    end else begin
      if (rd_hs_s && bus.rd_last_i && (rd_cnt_r != CntMax)) begin
        rd_cnt_r <= rd_cnt_r + CntOne;
      end
      if (wr_hs_s && (wr_cnt_r != CntMax)) begin
        wr_cnt_r <= wr_cnt_r + CntOne;
      end
    end
  end

  assign bus.rd_grant_cnt_o = rd_cnt_r;
  assign bus.wr_grant_cnt_o = wr_cnt_r;
`endif
endmodule

// File: tb/tb_simmem_release_arbiter.sv
// Bench for simmem_release_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
// Build with SIMMEM_ARB_STATS_EN defined to also exercise 2-bit saturating counters.
module tb_simmem_release_arbiter;
  localparam int IDW = 4;
  localparam int N   = 2 ** IDW;
`ifdef SIMMEM_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 32;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  simmem_release_arbiter_if #(.IDWidth(IDW), .CntWidth(CW)) bus ();

  simmem_release_arbiter #(.IDWidth(IDW), .CntWidth(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner = ID currently holding the channel (-1: none). A burst's first beat
  // is always offered; later beats are offered only when the bank has data.
  int     m_rd_ptr, m_rd_owner, m_wr_ptr, m_wr_owner;
  bit     m_rd_started;
  longint m_rd_cnt, m_wr_cnt;
  longint cnt_cap = (64'd1 << CW) - 64'd1;

  function automatic int first_elig(input logic [N-1:0] e, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (e[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    m_rd_ptr = 0; m_rd_owner = -1; m_rd_started = 0;
    m_wr_ptr = 0; m_wr_owner = -1;
    m_rd_cnt = 0; m_wr_cnt = 0;
  end

  // Compare process: outputs are checked on every falling edge.
  initial begin
    bit ev, ep;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_rd_ptr = 0; m_rd_owner = -1; m_rd_started = 0;
        m_wr_ptr = 0; m_wr_owner = -1;
        m_rd_cnt = 0; m_wr_cnt = 0;
        check("rst_rd_valid", bus.rd_out_valid_o, 0);
        check("rst_rd_pop", bus.rd_pop_o, 0);
        check("rst_wr_valid", bus.wr_out_valid_o, 0);
        check("rst_wr_pop", bus.wr_pop_o, 0);
`ifdef SIMMEM_ARB_STATS_EN
        check("rst_rd_cnt", bus.rd_grant_cnt_o, 0);
        check("rst_wr_cnt", bus.wr_grant_cnt_o, 0);
`endif
      end else begin
`ifdef SIMMEM_ARB_STATS_EN
        check("rd_cnt", bus.rd_grant_cnt_o, m_rd_cnt);
        check("wr_cnt", bus.wr_grant_cnt_o, m_wr_cnt);
`endif
        // read channel
        if (m_rd_owner < 0) begin
          ev = 0;
        end else begin
          ev = m_rd_started ? bus.rd_avail_i[m_rd_owner] : 1'b1;
        end
        ep = ev & bus.rd_out_ready_i;
        check("rd_valid", bus.rd_out_valid_o, ev);
        check("rd_pop", bus.rd_pop_o, ep);
        if (ev) check("rd_id", bus.rd_grant_id_o, m_rd_owner);
        if (m_rd_owner < 0) begin
          m_rd_owner   = first_elig(bus.rd_release_en_i & bus.rd_avail_i, m_rd_ptr);
          m_rd_started = 0;
        end else if (ep && bus.rd_last_i) begin
          m_rd_ptr   = (m_rd_owner + 1) % N;
          m_rd_owner = -1;
          if (m_rd_cnt < cnt_cap) m_rd_cnt++;
        end else if (ep) begin
          m_rd_started = 1;
        end
        // write channel
        ev = (m_wr_owner >= 0);
        ep = ev & bus.wr_out_ready_i;
        check("wr_valid", bus.wr_out_valid_o, ev);
        check("wr_pop", bus.wr_pop_o, ep);
        if (ev) check("wr_id", bus.wr_grant_id_o, m_wr_owner);
        if (m_wr_owner < 0) begin
          m_wr_owner = first_elig(bus.wr_release_en_i & bus.wr_avail_i, m_wr_ptr);
        end else if (ep) begin
          m_wr_ptr   = (m_wr_owner + 1) % N;
          m_wr_owner = -1;
          if (m_wr_cnt < cnt_cap) m_wr_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rd_release_en_i = '0; bus.rd_avail_i = '0;
    bus.rd_last_i = 1'b0;     bus.rd_out_ready_i = 1'b0;
    bus.wr_release_en_i = '0; bus.wr_avail_i = '0;
    bus.wr_out_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Wait (bounded) for a pop on one channel and check the popped ID.
  task automatic wait_pop(input bit wr, input int exp_id, input string name);
    bit found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (wr ? bus.wr_pop_o : bus.rd_pop_o) begin
        found = 1;
        check(name, wr ? bus.wr_grant_id_o : bus.rd_grant_id_o, exp_id);
      end
    end
    if (!found) check({name, "_timeout"}, -1, exp_id);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    clear_inputs();
    do_reset();

    // Round robin 3 -> 5 -> 3
    bus.rd_release_en_i = 16'h0028; bus.rd_avail_i = 16'h0028;
    bus.rd_out_ready_i = 1'b1;      bus.rd_last_i = 1'b1;
    wait_pop(1'b0, 3, "rr_first");
    wait_pop(1'b0, 5, "rr_second");
    wait_pop(1'b0, 3, "rr_wrap");

    // Burst lock: ID 2 four beats while ID 7 waits
    do_reset();
    bus.rd_release_en_i = 16'h0084; bus.rd_avail_i = 16'h0084;
    bus.rd_out_ready_i = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      bus.rd_last_i = (b == 4);
      wait_pop(1'b0, 2, "burst_beat");
    end
    @(negedge clk);
    check("burst_bubble_valid", bus.rd_out_valid_o, 0);
    tick();
    wait_pop(1'b0, 7, "burst_next");

    // Backpressure on ID 9, release enable withdrawn mid-wait
    do_reset();
    bus.rd_release_en_i = 16'h0200; bus.rd_avail_i = 16'h0200;
    bus.rd_last_i = 1'b1;
    begin
      bit seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        seen = bus.rd_out_valid_o;
      end
      check("bp_valid_seen", seen, 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();
        if (i == 2) bus.rd_release_en_i = '0;
        @(negedge clk);
      end
      check("bp_valid", bus.rd_out_valid_o, 1);
      check("bp_id", bus.rd_grant_id_o, 9);
      check("bp_pop", bus.rd_pop_o, 0);
    end
    tick();
    bus.rd_out_ready_i = 1'b1;
    wait_pop(1'b0, 9, "bp_release");

    // Write pointer wrap: ptr to 15, then 15 -> 0 -> 1
    do_reset();
    bus.wr_out_ready_i = 1'b1;
    bus.wr_release_en_i = 16'h4000; bus.wr_avail_i = 16'h4000;
    wait_pop(1'b1, 14, "wrap_setup");
    bus.wr_release_en_i = 16'h8001; bus.wr_avail_i = 16'h8001;
    wait_pop(1'b1, 15, "wrap_15");
    wait_pop(1'b1, 0, "wrap_0");
    bus.wr_release_en_i = 16'h8003; bus.wr_avail_i = 16'h8003;
    wait_pop(1'b1, 1, "wrap_ptr1");

    // Reset in LOCK after beat 2 of 4
    do_reset();
    bus.rd_out_ready_i = 1'b1; bus.rd_last_i = 1'b1;
    bus.rd_release_en_i = 16'h0020; bus.rd_avail_i = 16'h0020;
    wait_pop(1'b0, 5, "lockrst_setup");
    bus.rd_release_en_i = 16'h0004; bus.rd_avail_i = 16'h0004;
    bus.rd_last_i = 1'b0;
    wait_pop(1'b0, 2, "lockrst_beat1");
    wait_pop(1'b0, 2, "lockrst_beat2");
    rst = 1'b1;
    #1;
    check("lockrst_valid", bus.rd_out_valid_o, 0);
    check("lockrst_pop", bus.rd_pop_o, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.rd_release_en_i = 16'h0082; bus.rd_avail_i = 16'h0082;
    bus.rd_last_i = 1'b1;
    @(negedge clk);
    check("lockrst_idle", bus.rd_out_valid_o, 0);
    wait_pop(1'b0, 1, "lockrst_ptr0");

`ifdef SIMMEM_ARB_STATS_EN
    // Counters: 3 reads + 2 writes, then saturation at 3 after 5 reads
    do_reset();
    bus.rd_out_ready_i = 1'b1; bus.rd_last_i = 1'b1; bus.wr_out_ready_i = 1'b1;
    bus.rd_release_en_i = 16'h0010; bus.rd_avail_i = 16'h0010;
    for (int k = 0; k < 3; k++) wait_pop(1'b0, 4, "stats_rd");
    bus.rd_release_en_i = '0;
    bus.wr_release_en_i = 16'h0040; bus.wr_avail_i = 16'h0040;
    for (int k = 0; k < 2; k++) wait_pop(1'b1, 6, "stats_wr");
    bus.wr_release_en_i = '0;
    tick();
    @(negedge clk);
    check("stats_rd_cnt", bus.rd_grant_cnt_o, 3);
    check("stats_wr_cnt", bus.wr_grant_cnt_o, 2);
    tick();
    bus.rd_release_en_i = 16'h0010;
    for (int k = 0; k < 2; k++) wait_pop(1'b0, 4, "stats_rd_more");
    bus.rd_release_en_i = '0;
    tick();
    @(negedge clk);
    check("stats_rd_sat", bus.rd_grant_cnt_o, 3);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_release_en_i = N'($urandom() & $urandom());
        bus.rd_avail_i      = N'($urandom() | $urandom());
        bus.wr_release_en_i = N'($urandom() & $urandom());
        bus.wr_avail_i      = N'($urandom() | $urandom());
      end
      bus.rd_out_ready_i = ($urandom_range(0, 3) != 0);
      bus.wr_out_ready_i = ($urandom_range(0, 3) != 0);
      bus.rd_last_i      = ($urandom_range(0, 2) == 0);
    end
    tick();
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
